mul_sched: RTL and testbench
============================

Name: mul_sched

Overview:
- Sequencer and round-robin arbiter that shares one add-shift signed multiplier datapath (A/B shift registers, 9-bit adder/subtractor) among NREQ requesters.
- Picks one requester and drives the operand-select index for the external operand mux.
- Sequences the datapath's clear, load, add, subtract and shift controls for WIDTH bits.
- Pulses a per-requester done when the product in A:B is valid.

Parameters:
- NREQ, 2, number of requesters (2..8).
- WIDTH, 8, multiplier operand width, which is the number of add/shift iterations.

Ports:
- Clk  in  1  clock.
- Reset  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester level request; a request stays high until done is seen.
- M  in  1  current LSB of the datapath B register.
- gnt  out  NREQ  one-hot grant, registered; all zero when idle.
- sel  out  $clog2(NREQ)  index of the granted requester, drives the operand mux; held for the whole operation.
- busy  out  1  high from LOAD through DONE inclusive.
- Clr_A  out  1  clear the A register and X flip-flop.
- Ld_B  out  1  load the selected operand into B.
- Add  out  1  A <= A + S.
- Sub  out  1  A <= A - S.
- Shift  out  1  arithmetic right shift of X:A:B.
- done  out  NREQ  one-cycle pulse to the granted requester; the product is valid in that cycle.

Behaviour:
- Reset:
  - state = IDLE, count = 0, rr pointer = 0.
  - gnt, sel, busy, done and all datapath controls are 0.
  - Reset mid-operation aborts immediately; no done is issued.
- Outputs are decoded from state (Moore). At most one datapath control is high in any cycle.
- States and transitions:
  - IDLE: no controls asserted. If any req bit is set, grant the first set bit at or after the rr pointer (wrapping). Register gnt and sel, set rr pointer = granted+1 mod NREQ, go to LOAD. Otherwise stay in IDLE.
  - LOAD: Clr_A=1 and Ld_B=1 for exactly one cycle; count <= 0; go to CHECK.
  - CHECK: no controls asserted.
    - count == WIDTH: go to DONE.
    - else M==1 and count == WIDTH-1: go to SUB.
    - else M==1: go to ADD.
    - else: go to SHIFT.
  - ADD: Add=1, go to SHIFT.
  - SUB: Sub=1, go to SHIFT.
  - SHIFT: Shift=1, count <= count+1, go to CHECK.
  - DONE: done[sel]=1 for one cycle, go to IDLE. gnt and sel clear at the same edge.
- Count width is $clog2(WIDTH+1) bits, so count reaches exactly WIDTH with no wrap.
- Latency, where cycle 0 is the IDLE cycle that samples req:
  - LOAD is at cycle 1.
  - Each multiplier bit costs 2 cycles (M=0) or 3 cycles (M=1).
  - The final CHECK follows, then DONE.
  - For WIDTH=8, M always 0: done in cycle 19. M always 1: done in cycle 27.
- Minimum one IDLE cycle between operations, so back-to-back grants are 1 cycle after DONE.
- A requester deasserts req at the edge ending its done cycle. A req still high in the following IDLE cycle is a new request.
- If req drops mid-operation, the operation still completes and done is still pulsed. There is no abort except Reset.
- Simultaneous requests: rr order applies. No requester waits more than NREQ-1 operations.
- req bits that change during busy are ignored until IDLE.

Decomposition:
- mul_sched_pkg holds:
  - the state enum typedef (IDLE, LOAD, CHECK, ADD, SUB, SHIFT, DONE; 3-bit logic);
  - a function returning the count width for a given WIDTH.
- Sub-module rr_arbiter (parameter NREQ), purely combinational:
  - inputs: req, pointer, enable;
  - outputs: one-hot grant, grant index, any.
- The FSM, counter and rr pointer register stay in mul_sched.

Test Plan:
- Reset then idle: req=0 for 10 cycles -> gnt=0, busy=0, all controls 0. Reset asserted at state ADD -> next cycle IDLE, all outputs 0, no done pulse.
- Single request, M held 0, req=2'b01 -> LOAD at cycle 1 (Clr_A=Ld_B=1), 8 Shift pulses, 0 Add/Sub, done=2'b01 at cycle 19, sel=0 throughout.
- Single request, M held 1, req=2'b10 -> 7 Add pulses, 1 Sub (in the 8th iteration), 8 Shift pulses, done=2'b10 at cycle 27.
- Round-robin: req=2'b11 held continuously, each requester re-raising after its done -> grant sequence 0,1,0,1. Each done is followed by exactly one IDLE cycle before the next LOAD.
- Datapath in loop with an 8-bit Booth model: operands (-7)x(+5), (-128)x(-128), (+127)x(-1) -> A:B = -35, +16384, -127 at the done cycle.
- req dropped the cycle after LOAD -> operation completes and done is still pulsed at the nominal cycle. A new req from another requester during busy is granted only after IDLE.

Source files
------------

// File: rtl/mul_sched_pkg.sv
// Shared types for the add-shift multiplier sequencer: FSM state encoding and
// the iteration counter sizing helper.
package mul_sched_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        SHIFT = 3'd5,
        DONE  = 3'd6
    } state_t;

    // Counter must hold WIDTH itself, not just WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after pointer, wrapping.
// Zero latency; grants nothing while enable is low.
module rr_arbiter
    import mul_sched_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] pointer,
    input  logic                    enable,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] grant_idx,
    output logic                    any
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] j;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        j         = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = IW'((int'(pointer) + i) % NREQ);
            if (enable && !any && req[j]) begin
                grant[j]  = 1'b1;
                grant_idx = j;
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_sched.sv
// Shares one add-shift signed multiplier among NREQ requesters, round-robin.
// LOAD one cycle after the sampling IDLE cycle, 2 or 3 cycles per bit, then CHECK, DONE; req ignored while busy.
module mul_sched
    import mul_sched_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int WIDTH = 8
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [NREQ-1:0]         req,
    input  logic                    M,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] sel,
    output logic                    busy,
    output logic                    Clr_A,
    output logic                    Ld_B,
    output logic                    Add,
    output logic                    Sub,
    output logic                    Shift,
    output logic [NREQ-1:0]         done
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = cnt_width(WIDTH);

    state_t          state, state_nxt;
    logic [CW-1:0]   count;
    logic [IW-1:0]   rr_ptr;
    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (req),
        .pointer   (rr_ptr),
        .enable    (state == IDLE),
        .grant     (arb_gnt),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            count  <= '0;
            rr_ptr <= '0;
            gnt    <= '0;
            sel    <= '0;
        end else begin
            case (state)
                IDLE: if (arb_any) begin
                    gnt    <= arb_gnt;
                    sel    <= arb_idx;
                    rr_ptr <= IW'((int'(arb_idx) + 1) % NREQ);
                end
                LOAD:  count <= '0;
                SHIFT: count <= count + 1'b1;
                DONE: begin
                    gnt <= '0;
                    sel <= '0;
                end
                default: ;
            endcase
        end
    end

    // The last multiplier bit carries negative weight, so a set MSB subtracts.
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        Clr_A     = 1'b0;
        Ld_B      = 1'b0;
        Add       = 1'b0;
        Sub       = 1'b0;
        Shift     = 1'b0;
        done      = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (arb_any) state_nxt = LOAD;
            end
            LOAD: begin
                Clr_A     = 1'b1;
                Ld_B      = 1'b1;
                state_nxt = CHECK;
            end
            CHECK: begin
                if (count == CW'(WIDTH))                 state_nxt = DONE;
                else if (M && count == CW'(WIDTH - 1))   state_nxt = SUB;
                else if (M)                              state_nxt = ADD;
                else                                     state_nxt = SHIFT;
            end
            ADD: begin
                Add       = 1'b1;
                state_nxt = SHIFT;
            end
            SUB: begin
                Sub       = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                Shift     = 1'b1;
                state_nxt = CHECK;
            end
            DONE: begin
                done      = gnt;
                state_nxt = IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mul_sched.sv
// Self-checking bench for mul_sched with a signed add-shift datapath in the loop.
// Expected products, latencies and grant orders come from plain arithmetic on the operands.
module tb_mul_sched;

    localparam int NREQ  = 2;
    localparam int WIDTH = 8;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [1:0] req;
    logic       M;
    logic [1:0] gnt;
    logic [0:0] sel;
    logic       busy, Clr_A, Ld_B, Add, Sub, Shift;
    logic [1:0] done;

    int n_checks = 0;
    int n_fail   = 0;

    // 0: M from datapath B LSB, 1: M forced 0, 2: M forced 1
    int m_mode = 1;

    logic [7:0] mcand [2];
    logic [7:0] mplier[2];
    logic [7:0] dp_a, dp_b;
    logic       dp_x;

    mul_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .req   (req),
        .M     (M),
        .gnt   (gnt),
        .sel   (sel),
        .busy  (busy),
        .Clr_A (Clr_A),
        .Ld_B  (Ld_B),
        .Add   (Add),
        .Sub   (Sub),
        .Shift (Shift),
        .done  (done)
    );

    always #5 Clk = ~Clk;

    assign M = (m_mode == 0) ? dp_b[0] : (m_mode == 2);

    // Datapath: X:A:B registers, 9-bit add/subtract into X:A.
    always @(posedge Clk) begin
        if (Clr_A) begin
            dp_a <= 8'd0;
            dp_x <= 1'b0;
        end
        if (Ld_B) dp_b <= mplier[sel];
        if (Add) {dp_x, dp_a} <= {dp_a[7], dp_a} + {mcand[sel][7], mcand[sel]};
        if (Sub) {dp_x, dp_a} <= {dp_a[7], dp_a} - {mcand[sel][7], mcand[sel]};
        if (Shift) begin
            dp_a <= {dp_x, dp_a[7:1]};
            dp_b <= {dp_a[0], dp_b[7:1]};
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        req   = 2'b00;
        step();
        step();
        Reset = 1'b0;
        step();
    endtask

    // Cycle of the done pulse, counting the req-sampling IDLE cycle as 0.
    function automatic int exp_done_cycle(input logic [7:0] mb);
        int c;
        c = 3;
        for (int i = 0; i < WIDTH; i++) c += 2 + int'(mb[i]);
        return c;
    endfunction

    function automatic logic [15:0] exp_product(input logic [7:0] a, input logic [7:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[15:0];
    endfunction

    // Drives one operation and reports what it saw; the callers do the comparing.
    task automatic run_op(input logic [1:0] r, input logic drop_after_load, input logic [1:0] raise_mid,
                          output int done_cyc, output logic [1:0] done_v,
                          output int n_add, output int n_sub, output int n_shift,
                          output logic [15:0] prod, output logic load_ok, output logic [1:0] load_gnt,
                          output logic [0:0] load_sel, output logic hold_ok, output logic idle_ok);
        done_cyc = -1;
        done_v   = 2'b00;
        n_add    = 0;
        n_sub    = 0;
        n_shift  = 0;
        prod     = 16'h0;
        load_ok  = 1'b0;
        load_gnt = 2'b00;
        load_sel = 1'b0;
        hold_ok  = 1'b1;
        idle_ok  = 1'b0;
        req      = r;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            step();
            if (cyc == 1) begin
                load_ok  = Clr_A && Ld_B && busy && !Add && !Sub && !Shift;
                load_gnt = gnt;
                load_sel = sel;
                if (drop_after_load) req = 2'b00;
            end else begin
                if (Clr_A || Ld_B || $countones({Add, Sub, Shift}) > 1) hold_ok = 1'b0;
                if (sel != load_sel || gnt != load_gnt || !busy) hold_ok = 1'b0;
                n_add   += int'(Add);
                n_sub   += int'(Sub);
                n_shift += int'(Shift);
                if (cyc == 3) req = req | raise_mid;
                if (done != 2'b00) begin
                    done_cyc = cyc;
                    done_v   = done;
                    prod     = {dp_a, dp_b};
                    break;
                end
            end
        end
        step();
        idle_ok = (gnt == 2'b00) && !busy && (done == 2'b00);
        req = req & ~done_v;
    endtask

    task automatic test_reset();
        logic found;
        logic stray;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if ({gnt, sel, busy, done, Clr_A, Ld_B, Add, Sub, Shift} !== 11'b0) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: outputs=%b required all zero", i,
                         {gnt, sel, busy, done, Clr_A, Ld_B, Add, Sub, Shift});
            end
            step();
        end
        m_mode = 2;
        req    = 2'b01;
        found  = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (Add) found = 1'b1;
        end
        n_checks++;
        if (found !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_reach_add: Add seen=%b required 1", found);
        end
        Reset = 1'b1;
        req   = 2'b00;
        step();
        n_checks++;
        if ({gnt, sel, busy, done, Clr_A, Ld_B, Add, Sub, Shift} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_at_add: outputs=%b required all zero",
                     {gnt, sel, busy, done, Clr_A, Ld_B, Add, Sub, Shift});
        end
        Reset = 1'b0;
        stray = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done != 2'b00 || busy) stray = 1'b1;
        end
        n_checks++;
        if (stray !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_done: activity after abort=%b required 0", stray);
        end
    endtask

    task automatic test_single(input int mm, input logic [1:0] r, input logic [7:0] mbits);
        int dc, na, ns, nsh;
        logic [1:0] dv, lg;
        logic [0:0] ls;
        logic [15:0] p;
        logic lok, hok, iok;
        int exp_add;
        do_reset();
        m_mode = mm;
        run_op(r, 1'b0, 2'b00, dc, dv, na, ns, nsh, p, lok, lg, ls, hok, iok);
        exp_add = $countones(mbits[6:0]);
        n_checks++;
        if (lok !== 1'b1 || lg !== r || ls !== 1'(r == 2'b10)) begin
            n_fail++;
            $display("FAIL single_load m=%0d: load_ok=%b gnt=%b sel=%b required 1 %b %b", mm, lok, lg, ls, r, r == 2'b10);
        end
        n_checks++;
        if (na != exp_add || ns != int'(mbits[7]) || nsh != WIDTH) begin
            n_fail++;
            $display("FAIL single_ctl m=%0d: add=%0d sub=%0d shift=%0d required %0d %0d %0d",
                     mm, na, ns, nsh, exp_add, mbits[7], WIDTH);
        end
        n_checks++;
        if (dc != exp_done_cycle(mbits) || dv !== r) begin
            n_fail++;
            $display("FAIL single_done m=%0d: cycle=%0d done=%b required %0d %b", mm, dc, dv, exp_done_cycle(mbits), r);
        end
        n_checks++;
        if (hok !== 1'b1 || iok !== 1'b1) begin
            n_fail++;
            $display("FAIL single_hold m=%0d: hold_ok=%b idle_ok=%b required 1 1", mm, hok, iok);
        end
    endtask

    task automatic test_datapath();
        logic [7:0] ta[3] = '{8'hF9, 8'h80, 8'h7F};
        logic [7:0] tb[3] = '{8'h05, 8'h80, 8'hFF};
        int dc, na, ns, nsh, k;
        logic [1:0] dv, lg;
        logic [0:0] ls;
        logic [15:0] p;
        logic lok, hok, iok;
        m_mode = 0;
        for (int t = 0; t < 9; t++) begin
            k = (t < 3) ? 0 : int'($urandom_range(0, 1));
            if (t < 3) begin
                mcand[k]  = ta[t];
                mplier[k] = tb[t];
            end else begin
                mcand[k]  = 8'($urandom);
                mplier[k] = 8'($urandom);
            end
            mcand[1-k]  = 8'($urandom);
            mplier[1-k] = 8'($urandom);
            do_reset();
            run_op(2'(1 << k), 1'b0, 2'b00, dc, dv, na, ns, nsh, p, lok, lg, ls, hok, iok);
            n_checks++;
            if (p !== exp_product(mcand[k], mplier[k])) begin
                n_fail++;
                $display("FAIL dp_product %0d: %0d x %0d got %h required %h", t,
                         $signed(mcand[k]), $signed(mplier[k]), p, exp_product(mcand[k], mplier[k]));
            end
            n_checks++;
            if (dc != exp_done_cycle(mplier[k]) || dv !== 2'(1 << k)) begin
                n_fail++;
                $display("FAIL dp_done %0d: cycle=%0d done=%b required %0d %b", t, dc, dv,
                         exp_done_cycle(mplier[k]), 2'(1 << k));
            end
        end
    endtask

    task automatic test_round_robin();
        int load_cyc[$];
        int done_cyc[$];
        logic [1:0] load_g[$];
        logic [1:0] exp_g;
        do_reset();
        m_mode = 1;
        req    = 2'b11;
        for (int cyc = 1; cyc <= 300 && done_cyc.size() < 4; cyc++) begin
            step();
            if (Clr_A) begin
                load_cyc.push_back(cyc);
                load_g.push_back(gnt);
            end
            if (done != 2'b00) done_cyc.push_back(cyc);
        end
        n_checks++;
        if (done_cyc.size() != 4 || load_g.size() < 4) begin
            n_fail++;
            $display("FAIL rr_count: dones=%0d loads=%0d required 4 4", done_cyc.size(), load_g.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
                n_checks++;
                if (load_g[i] !== exp_g) begin
                    n_fail++;
                    $display("FAIL rr_grant %0d: gnt=%b required %b", i, load_g[i], exp_g);
                end
            end
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (load_cyc[i+1] - done_cyc[i] != 2) begin
                    n_fail++;
                    $display("FAIL rr_gap %0d: done->load=%0d required 2", i, load_cyc[i+1] - done_cyc[i]);
                end
            end
        end
        req = 2'b00;
    endtask

    task automatic test_drop_and_late();
        int dc, na, ns, nsh;
        logic [1:0] dv, lg;
        logic [0:0] ls;
        logic [15:0] p;
        logic lok, hok, iok;
        do_reset();
        m_mode    = 0;
        mcand[0]  = 8'($urandom);
        mplier[0] = 8'($urandom);
        mcand[1]  = 8'($urandom);
        mplier[1] = 8'($urandom);
        run_op(2'b01, 1'b1, 2'b10, dc, dv, na, ns, nsh, p, lok, lg, ls, hok, iok);
        n_checks++;
        if (dc != exp_done_cycle(mplier[0]) || dv !== 2'b01) begin
            n_fail++;
            $display("FAIL drop_done: cycle=%0d done=%b required %0d 01", dc, dv, exp_done_cycle(mplier[0]));
        end
        n_checks++;
        if (hok !== 1'b1 || p !== exp_product(mcand[0], mplier[0])) begin
            n_fail++;
            $display("FAIL drop_hold: hold_ok=%b product=%h required 1 %h", hok, p, exp_product(mcand[0], mplier[0]));
        end
        n_checks++;
        if (iok !== 1'b1) begin
            n_fail++;
            $display("FAIL late_idle: idle after done=%b required 1", iok);
        end
        step();
        n_checks++;
        if (Clr_A !== 1'b1 || gnt !== 2'b10 || sel !== 1'b1) begin
            n_fail++;
            $display("FAIL late_grant: Clr_A=%b gnt=%b sel=%b required 1 10 1", Clr_A, gnt, sel);
        end
        req = 2'b00;
        do_reset();
    endtask

    initial begin
        Reset = 1'b1;
        req   = 2'b00;
        for (int i = 0; i < 2; i++) begin
            mcand[i]  = 8'h00;
            mplier[i] = 8'h00;
        end
        test_reset();
        test_single(1, 2'b01, 8'h00);
        test_single(2, 2'b10, 8'hFF);
        test_datapath();
        test_round_robin();
        test_drop_and_late();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
